// File: rtl/ncpu32k_ifu_fetchq_pkg.sv
// Shared configuration for the instruction-fetch queue: default widths, queue
// geometry and the bit layout of the 2-bit fetch exception tag.
package ncpu32k_ifu_fetchq_pkg;

  localparam int NCPU_AW          = 32;
  localparam int NCPU_IW          = 32;
  localparam int NCPU_IFQ_DEPTH   = 4;
  localparam int NCPU_IFQ_MAX_OUT = 2;

  localparam int NCPU_IFQ_EXC_W   = 2;
  localparam int NCPU_IFQ_EXC_ITM = 0;  // TLB miss
  localparam int NCPU_IFQ_EXC_IPF = 1;  // page fault

  function automatic logic exc_any(input logic [NCPU_IFQ_EXC_W-1:0] exc);
    return exc[NCPU_IFQ_EXC_ITM] | exc[NCPU_IFQ_EXC_IPF];
  endfunction

endpackage

// File: rtl/ncpu32k_ifu_fq_buf.sv
// Circular instruction buffer: DEPTH entries of packed {insn, pc, exc}, with
// occupancy count, zeroed head when empty, and single-cycle flush.
module ncpu32k_ifu_fq_buf #(
  parameter int DEPTH = 4,
  parameter int DW    = 62,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic          valid,
  output logic [DW-1:0] dout,
  output logic [CW-1:0] count
);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // NOTE: storage has no reset; count gates every read, so stale data never escapes.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign valid = (count != '0);
  assign dout  = valid ? mem[rd_ptr] : '0;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && count == CW'(DEPTH)));

endmodule

// File: rtl/ncpu32k_ifu_fetchq.sv
// Decoupled fetch front end: credit-limited ibus issue, in-order response
// capture into the insn queue, drop counter for abandoned fetches.
module ncpu32k_ifu_fetchq
  import ncpu32k_ifu_fetchq_pkg::*;
#(
  parameter int          AW        = NCPU_AW,
  parameter int          IW        = NCPU_IW,
  parameter int          DEPTH     = NCPU_IFQ_DEPTH,
  parameter int          MAX_OUT   = NCPU_IFQ_MAX_OUT,
  parameter logic [AW-1:0] RESET_PC = '0,
  parameter int          START_DLY = 2,
  localparam int         PCW       = AW - 2,
  localparam int         CW        = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  output logic           ibus_cmd_valid,
  input  logic           ibus_cmd_ready,
  output logic [AW-1:0]  ibus_cmd_addr,
  input  logic           ibus_valid,
  output logic           ibus_ready,
  input  logic [IW-1:0]  ibus_dout,
  input  logic [1:0]     ibus_exc,
  output logic           ibus_flush_req,
  input  logic           redirect_valid,
  input  logic [PCW-1:0] redirect_tgt,
  output logic           idu_in_valid,
  input  logic           idu_in_ready,
  output logic [IW-1:0]  idu_insn,
  output logic [PCW-1:0] idu_insn_pc,
  output logic [1:0]     idu_exc,
  output logic [CW-1:0]  fq_count
);

  localparam int OW = $clog2(MAX_OUT + 1);
  localparam int DW = IW + PCW + 2;

  logic [2:0]     start_cnt;
  logic           started;
  logic [OW-1:0]  inflight, inflight_nxt;
  logic [OW-1:0]  drop_cnt, drop_nxt;
  logic           halt, halt_nxt;
  logic [PCW-1:0] fetch_pc, fetch_pc_nxt;
  logic [PCW-1:0] resp_pc, resp_pc_nxt;

  logic cmd_hs, resp_hs, push, pop, exc_push, credit_ok;
  logic [DW-1:0] head;

  assign started   = (start_cnt == 3'(START_DLY));
  // Counting queued plus outstanding fetches guarantees every response a slot.
  assign credit_ok = (inflight < OW'(MAX_OUT)) &&
                     ((32'(inflight) + 32'(fq_count)) < 32'(DEPTH));

  assign ibus_cmd_valid = started & ~halt & ~redirect_valid & credit_ok;
  assign ibus_cmd_addr  = {fetch_pc, 2'b00};
  assign ibus_ready     = started;
  assign ibus_flush_req = redirect_valid;

  assign cmd_hs   = ibus_cmd_valid & ibus_cmd_ready;
  assign resp_hs  = ibus_valid & ibus_ready;
  assign push     = resp_hs & ~redirect_valid & (drop_cnt == '0);
  assign exc_push = push & exc_any(ibus_exc);
  assign pop      = idu_in_valid & idu_in_ready;

  always_comb begin
    // NOTE: every output of this block is defaulted first, so no latch can be inferred.
    inflight_nxt = inflight + OW'(cmd_hs) - OW'(resp_hs);
    drop_nxt     = drop_cnt;
    halt_nxt     = halt;
    fetch_pc_nxt = fetch_pc;
    resp_pc_nxt  = resp_pc;
    if (cmd_hs) fetch_pc_nxt = fetch_pc + PCW'(1);
    if (push)   resp_pc_nxt  = resp_pc + PCW'(1);
    if (resp_hs && drop_cnt != '0) drop_nxt = drop_cnt - OW'(1);
    // Anything still outstanding after a faulting fetch belongs to a dead stream.
    if (exc_push) begin
      halt_nxt = 1'b1;
      drop_nxt = inflight_nxt;
    end
    if (redirect_valid) begin
      halt_nxt     = 1'b0;
      drop_nxt     = inflight_nxt;
      fetch_pc_nxt = redirect_tgt;
      resp_pc_nxt  = redirect_tgt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      start_cnt <= '0;
      inflight  <= '0;
      drop_cnt  <= '0;
      halt      <= 1'b0;
      fetch_pc  <= RESET_PC[AW-1:2];
      resp_pc   <= RESET_PC[AW-1:2];
    end else begin
      if (!started) start_cnt <= start_cnt + 3'd1;
      inflight <= inflight_nxt;
      drop_cnt <= drop_nxt;
      halt     <= halt_nxt;
      fetch_pc <= fetch_pc_nxt;
      resp_pc  <= resp_pc_nxt;
    end
  end

  ncpu32k_ifu_fq_buf #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (redirect_valid),
    .push  (push),
    .din   ({ibus_dout, resp_pc, ibus_exc}),
    .pop   (pop),
    .valid (idu_in_valid),
    .dout  (head),
    .count (fq_count)
  );

  assign idu_insn    = head[DW-1 -: IW];
  assign idu_insn_pc = head[2 +: PCW];
  assign idu_exc     = head[1:0];

  a_no_orphan_resp: assert property (@(posedge clk) disable iff (!rst_n)
    !(resp_hs && inflight == '0));

endmodule

// File: tb/tb_ncpu32k_ifu_fetchq.sv
// Bench for the fetch queue: an in-order ibus responder, a PC-stream scoreboard
// checking every command and every IDU pop, and directed scenarios plus a random run.
module tb_ncpu32k_ifu_fetchq;

  localparam int AW = 32, IW = 32, DEPTH = 4, MAX_OUT = 2, START_DLY = 2;
  localparam int PCW = AW - 2, CW = $clog2(DEPTH + 1);

  typedef enum int {R_HOLD, R_ALWAYS, R_RAND} resp_mode_e;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           ibus_cmd_valid, ibus_cmd_ready;
  logic [AW-1:0]  ibus_cmd_addr;
  logic           ibus_valid, ibus_ready;
  logic [IW-1:0]  ibus_dout;
  logic [1:0]     ibus_exc;
  logic           ibus_flush_req;
  logic           redirect_valid;
  logic [PCW-1:0] redirect_tgt;
  logic           idu_in_valid, idu_in_ready;
  logic [IW-1:0]  idu_insn;
  logic [PCW-1:0] idu_insn_pc;
  logic [1:0]     idu_exc;
  logic [CW-1:0]  fq_count;

  ncpu32k_ifu_fetchq #(
    .AW(AW), .IW(IW), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT),
    .RESET_PC(32'h0), .START_DLY(START_DLY)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ibus_cmd_valid(ibus_cmd_valid), .ibus_cmd_ready(ibus_cmd_ready),
    .ibus_cmd_addr(ibus_cmd_addr), .ibus_valid(ibus_valid), .ibus_ready(ibus_ready),
    .ibus_dout(ibus_dout), .ibus_exc(ibus_exc), .ibus_flush_req(ibus_flush_req),
    .redirect_valid(redirect_valid), .redirect_tgt(redirect_tgt),
    .idu_in_valid(idu_in_valid), .idu_in_ready(idu_in_ready),
    .idu_insn(idu_insn), .idu_insn_pc(idu_insn_pc), .idu_exc(idu_exc),
    .fq_count(fq_count)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int n_cmd = 0, n_pop = 0;
  logic [PCW-1:0] last_pc;
  logic [1:0]     last_exc;
  resp_mode_e     resp_mode = R_ALWAYS;
  logic           force_valid = 1'b0;
  logic [PCW-1:0] pending [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [IW-1:0] insn_of(input logic [PCW-1:0] pc);
    return {2'b10, pc} ^ 32'h0F0F_0F0F;
  endfunction

  function automatic logic [1:0] exc_of(input logic [PCW-1:0] pc);
    case (pc)
      30'h8:   return 2'b01;
      30'h31:  return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  // ibus responder: answers outstanding commands in order, from its own table.
  initial begin
    ibus_valid = 1'b0;
    ibus_dout  = '0;
    ibus_exc   = '0;
    forever begin
      @(posedge clk);
      #2;
      if (rst_n && pending.size() > 0 &&
          (resp_mode == R_ALWAYS || force_valid ||
           (resp_mode == R_RAND && $urandom_range(1, 0) == 1))) begin
        ibus_valid = 1'b1;
        ibus_dout  = insn_of(pending[0]);
        ibus_exc   = exc_of(pending[0]);
      end else begin
        ibus_valid = 1'b0;
        ibus_dout  = '0;
        ibus_exc   = '0;
      end
    end
  end

  // Monitor / scoreboard: expected fetch-address and PC streams restart on redirect.
  initial begin
    logic [PCW-1:0] exp_fetch, exp_pc;
    logic halted_exp, redir_prev;
    exp_fetch = '0;
    exp_pc = '0;
    halted_exp = 1'b0;
    redir_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pending.delete();
        redir_prev = 1'b0;
        continue;
      end
      if (redir_prev) begin
        check("flush_clears_count", 64'(fq_count), 0);
        check("flush_clears_valid", 64'(idu_in_valid), 0);
      end
      if (!idu_in_valid) check("empty_head_zero", {idu_insn, idu_insn_pc, idu_exc}, 0);
      if (halted_exp) check("no_cmd_after_exc", 64'(ibus_cmd_valid), 0);
      check("flush_req", 64'(ibus_flush_req), 64'(redirect_valid));
      if (redirect_valid) check("no_cmd_in_redirect", 64'(ibus_cmd_valid), 0);
      if (ibus_cmd_valid && ibus_cmd_ready) begin
        check("cmd_addr", 64'(ibus_cmd_addr), 64'({exp_fetch, 2'b00}));
        exp_fetch = exp_fetch + 1'b1;
        pending.push_back(ibus_cmd_addr[AW-1:2]);
        n_cmd++;
      end
      if (ibus_valid && ibus_ready && pending.size() > 0) void'(pending.pop_front());
      if (idu_in_valid && idu_in_ready) begin
        check("no_pop_after_exc", 64'(halted_exp), 0);
        check("pop_pc",   64'(idu_insn_pc), 64'(exp_pc));
        check("pop_insn", 64'(idu_insn), 64'(insn_of(exp_pc)));
        check("pop_exc",  64'(idu_exc), 64'(exc_of(exp_pc)));
        last_pc  = idu_insn_pc;
        last_exc = idu_exc;
        n_pop++;
        if (exc_of(exp_pc) != 2'b00) halted_exp = 1'b1;
        exp_pc = exp_pc + 1'b1;
      end
      if (redirect_valid) begin
        exp_pc     = redirect_tgt;
        exp_fetch  = redirect_tgt;
        halted_exp = 1'b0;
      end
      redir_prev = redirect_valid;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect(input logic [PCW-1:0] tgt);
    redirect_valid = 1'b1;
    redirect_tgt   = tgt;
    next_cycle();
    redirect_valid = 1'b0;
  endtask

  task automatic wait_pop(input int target, input int budget);
    int k = 0;
    while (n_pop < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("pop_within_budget", 64'(n_pop >= target), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    int n0, p0;
    rst_n = 1'b0;
    ibus_cmd_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_tgt = '0;
    idu_in_ready = 1'b0;
    repeat (3) next_cycle();

    // Reset state
    @(negedge clk);
    check("rst_cmd_valid", 64'(ibus_cmd_valid), 0);
    check("rst_ibus_ready", 64'(ibus_ready), 0);
    check("rst_idu_valid", 64'(idu_in_valid), 0);
    check("rst_head", {idu_insn, idu_insn_pc, idu_exc}, 0);
    check("rst_count", 64'(fq_count), 0);
    check("rst_cmd_addr", 64'(ibus_cmd_addr), 0);

    // Start delay, then streaming from 0x0 until the faulting fetch at byte 0x20
    next_cycle();
    rst_n = 1'b1;
    ibus_cmd_ready = 1'b1;
    idu_in_ready = 1'b1;
    for (int i = 0; i <= START_DLY; i++) begin
      @(negedge clk);
      check("start_cmd_valid", 64'(ibus_cmd_valid), 64'(i == START_DLY));
      check("start_ibus_ready", 64'(ibus_ready), 64'(i == START_DLY));
    end
    wait_pop(9, 80);
    check("exc_pc", 64'(last_pc), 64'h8);
    check("exc_tag", 64'(last_exc), 64'h1);
    repeat (20) next_cycle();
    @(negedge clk);
    check("halt_cmd_valid", 64'(ibus_cmd_valid), 0);
    check("halt_count", 64'(fq_count), 0);

    // IDU stalled: exactly DEPTH commands, then refill after one pop
    next_cycle();
    idu_in_ready = 1'b0;
    redirect(30'h100);
    n0 = n_cmd;
    repeat (20) next_cycle();
    @(negedge clk);
    check("stall_cmds", 64'(n_cmd - n0), 64'(DEPTH));
    check("stall_count", 64'(fq_count), 64'(DEPTH));
    check("stall_cmd_valid", 64'(ibus_cmd_valid), 0);
    next_cycle();
    idu_in_ready = 1'b1;
    n0 = n_cmd;
    next_cycle();
    idu_in_ready = 1'b0;
    repeat (6) next_cycle();
    @(negedge clk);
    check("refill_one_cmd", 64'(n_cmd - n0), 1);
    check("refill_count", 64'(fq_count), 64'(DEPTH));
    next_cycle();
    idu_in_ready = 1'b1;
    repeat (10) next_cycle();

    // Two commands in flight (0x10, 0x14) then redirect to word 0x10
    ibus_cmd_ready = 1'b0;
    repeat (5) next_cycle();
    resp_mode = R_HOLD;
    ibus_cmd_ready = 1'b1;
    redirect(30'h4);
    n0 = n_cmd;
    repeat (6) next_cycle();
    @(negedge clk);
    check("two_inflight", 64'(n_cmd - n0), 2);
    check("max_out_block", 64'(ibus_cmd_valid), 0);
    next_cycle();
    resp_mode = R_ALWAYS;
    p0 = n_pop;
    redirect(30'h10);
    wait_pop(p0 + 1, 20);
    check("after_redirect_pc", 64'(last_pc), 64'h10);

    // Redirect in the same cycle as a response handshake and an IDU pop
    next_cycle();
    ibus_cmd_ready = 1'b0;
    idu_in_ready = 1'b0;
    repeat (5) next_cycle();
    resp_mode = R_HOLD;
    ibus_cmd_ready = 1'b1;
    redirect(30'h40);
    repeat (5) next_cycle();
    ibus_cmd_ready = 1'b0;
    force_valid = 1'b1;
    next_cycle();
    idu_in_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_tgt = 30'h50;
    @(negedge clk);
    check("coinc_resp_hs", 64'(ibus_valid && ibus_ready), 1);
    check("coinc_pop", 64'(idu_in_valid && idu_in_ready), 1);
    check("coinc_flush_req", 64'(ibus_flush_req), 1);
    next_cycle();
    force_valid = 1'b0;
    redirect_valid = 1'b0;
    idu_in_ready = 1'b0;
    @(negedge clk);
    check("coinc_count", 64'(fq_count), 0);
    next_cycle();
    p0 = n_pop;
    resp_mode = R_ALWAYS;
    ibus_cmd_ready = 1'b1;
    idu_in_ready = 1'b1;
    wait_pop(p0 + 1, 20);
    check("coinc_next_pc", 64'(last_pc), 64'h50);

    // Random handshakes and redirects against the PC-stream scoreboard
    resp_mode = R_RAND;
    p0 = n_pop;
    for (int i = 0; i < 3000; i++) begin
      ibus_cmd_ready = ($urandom_range(3, 0) != 0);
      idu_in_ready   = ($urandom_range(3, 0) != 0);
      redirect_valid = ($urandom_range(31, 0) == 0);
      redirect_tgt   = PCW'($urandom_range(63, 0));
      next_cycle();
    end
    redirect_valid = 1'b0;
    repeat (5) next_cycle();
    check("random_progress", 64'(n_pop - p0 > 200), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
